// File: rtl/cordic_iter_hs_if.sv
// Valid/ready operand and result channels of the iterative CORDIC engine.
// The slave modport is the engine side; master is the producer/consumer side.
interface cordic_iter_hs_if #(
    parameter int XY_BITS = 16,
    parameter int PH_BITS = 32
);
    logic                      valid_in;
    logic                      ready_out;
    logic                      mode_in;
    logic signed [XY_BITS-1:0] x_i;
    logic signed [XY_BITS-1:0] y_i;
    logic        [PH_BITS-1:0] phase_in;
    logic                      valid_out;
    logic                      ready_in;
    logic signed [XY_BITS+1:0] x_o;
    logic signed [XY_BITS+1:0] y_o;
    logic        [PH_BITS-1:0] phase_out;

    modport slave (
        input  valid_in, mode_in, x_i, y_i, phase_in, ready_in,
        output ready_out, valid_out, x_o, y_o, phase_out
    );

    modport master (
        output valid_in, mode_in, x_i, y_i, phase_in, ready_in,
        input  ready_out, valid_out, x_o, y_o, phase_out
    );
endinterface

// File: rtl/cordic_iter_hs.sv
// Iterative CORDIC (one micro-rotation per clock), ROTATE/VECTOR, valid/ready on both sides.
// Optional macro CORDIC_GAIN_COMP_EN adds a COMP state that scales x/y back to unity gain.
module cordic_iter_hs #(
    parameter int XY_BITS    = 16,
    parameter int PH_BITS    = 32,
    parameter int ITERATIONS = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    cordic_iter_hs_if.slave  bus,
    output logic             busy
);
    localparam int W  = XY_BITS + 2;
    localparam int CW = $clog2(ITERATIONS);
    localparam logic [PH_BITS-1:0] HALF = {1'b1, {(PH_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
`ifdef CORDIC_GAIN_COMP_EN
        COMP,
`endif
        HOLD
    } state_t;

    state_t                    state_q;
    logic         [CW-1:0]     iter_q;
    logic                      ready_out_q;
    logic                      valid_out_q;
    logic                      busy_q;
    logic signed  [W-1:0]      x_o_q;
    logic signed  [W-1:0]      y_o_q;
    logic         [PH_BITS-1:0] ph_o_q;

    logic                      mode_q;
    logic signed  [W-1:0]      x_q;
    logic signed  [W-1:0]      y_q;
    logic signed  [PH_BITS-1:0] z_q;

    logic                      accept;
    logic                      flip;
    logic signed  [W-1:0]      x_ext, y_ext, x_pre, y_pre;
    logic         [PH_BITS-1:0] z_pre;
    logic signed  [W-1:0]      x_sh, y_sh, x_d, y_d;
    logic         [PH_BITS-1:0] z_d;
    logic         [31:0]       atan_full;
    logic         [PH_BITS-1:0] atan_i;
    logic                      d_pos;

    // round(atan(2^-i) * 2^32 / (2*pi))
    function automatic logic [31:0] atan_tab(input logic [4:0] idx);
        case (idx)
            5'd0:  atan_tab = 32'h2000_0000;
            5'd1:  atan_tab = 32'h12E4_051E;
            5'd2:  atan_tab = 32'h09FB_385B;
            5'd3:  atan_tab = 32'h0511_11D4;
            5'd4:  atan_tab = 32'h028B_0D43;
            5'd5:  atan_tab = 32'h0145_D7E1;
            5'd6:  atan_tab = 32'h00A2_F61E;
            5'd7:  atan_tab = 32'h0051_7C55;
            5'd8:  atan_tab = 32'h0028_BE53;
            5'd9:  atan_tab = 32'h0014_5F2F;
            5'd10: atan_tab = 32'h000A_2F98;
            5'd11: atan_tab = 32'h0005_17CC;
            5'd12: atan_tab = 32'h0002_8BE6;
            5'd13: atan_tab = 32'h0001_45F3;
            5'd14: atan_tab = 32'h0000_A2FA;
            5'd15: atan_tab = 32'h0000_517D;
            5'd16: atan_tab = 32'h0000_28BE;
            5'd17: atan_tab = 32'h0000_145F;
            5'd18: atan_tab = 32'h0000_0A30;
            5'd19: atan_tab = 32'h0000_0518;
            5'd20: atan_tab = 32'h0000_028C;
            5'd21: atan_tab = 32'h0000_0146;
            5'd22: atan_tab = 32'h0000_00A3;
            5'd23: atan_tab = 32'h0000_0051;
            5'd24: atan_tab = 32'h0000_0029;
            5'd25: atan_tab = 32'h0000_0014;
            5'd26: atan_tab = 32'h0000_000A;
            5'd27: atan_tab = 32'h0000_0005;
            5'd28: atan_tab = 32'h0000_0003;
            5'd29: atan_tab = 32'h0000_0001;
            5'd30: atan_tab = 32'h0000_0001;
            default: atan_tab = 32'h0000_0000;
        endcase
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [17:0] K_GAIN = 18'sd39797;

    // v * K / 2^16, rounded half-up
    function automatic logic signed [W-1:0] gain_round(input logic signed [W-1:0] v);
        logic signed [W+17:0] p;
        logic signed [W+17:0] s;
        p = (W+18)'(v) * (W+18)'(K_GAIN);
        p = p + (W+18)'(32'sd32768);
        s = p >>> 16;
        gain_round = s[W-1:0];
    endfunction
`endif

    assign accept = (state_q == IDLE) && ready_out_q && bus.valid_in;

    // Quadrant pre-rotation: fold the operand into +-90 deg by a 180 deg turn.
    always_comb begin
        x_ext = {{2{bus.x_i[XY_BITS-1]}}, bus.x_i};
        y_ext = {{2{bus.y_i[XY_BITS-1]}}, bus.y_i};
        flip  = bus.mode_in ? bus.x_i[XY_BITS-1]
                            : (bus.phase_in[PH_BITS-1] ^ bus.phase_in[PH_BITS-2]);
        x_pre = flip ? -x_ext : x_ext;
        y_pre = flip ? -y_ext : y_ext;
        z_pre = bus.phase_in;
        if (flip)
            z_pre = bus.mode_in ? bus.phase_in + HALF : bus.phase_in - HALF;
    end

    always_comb begin
        x_sh      = x_q >>> iter_q;
        y_sh      = y_q >>> iter_q;
        atan_full = atan_tab(5'(iter_q)) >> (32 - PH_BITS);
        atan_i    = atan_full[PH_BITS-1:0];
        d_pos     = mode_q ? y_q[W-1] : ~z_q[PH_BITS-1];
        if (d_pos) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_i;
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_i;
        end
    end

    // Working datapath registers carry no reset; control below qualifies them.
    always_ff @(posedge clk_in) begin
        case (state_q)
            IDLE: if (accept) begin
                mode_q <= bus.mode_in;
                x_q    <= x_pre;
                y_q    <= y_pre;
                z_q    <= z_pre;
            end
            RUN: begin
                x_q <= x_d;
                y_q <= y_d;
                z_q <= z_d;
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
                x_q <= gain_round(x_q);
                y_q <= gain_round(y_q);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            ready_out_q <= 1'b0;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
            x_o_q       <= '0;
            y_o_q       <= '0;
            ph_o_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ready_out_q <= 1'b0;
                        busy_q      <= 1'b1;
                        iter_q      <= '0;
                        state_q     <= RUN;
                    end else begin
                        ready_out_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (iter_q == CW'(ITERATIONS-1)) begin
                        busy_q  <= 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
                        state_q <= COMP;
`else
                        state_q <= HOLD;
`endif
                    end else begin
                        iter_q <= iter_q + CW'(1);
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                COMP: state_q <= HOLD;
`endif
                HOLD: begin
                    // First HOLD cycle registers the result; it then stays put until taken.
                    if (!valid_out_q) begin
                        x_o_q       <= x_q;
                        y_o_q       <= y_q;
                        ph_o_q      <= z_q;
                        valid_out_q <= 1'b1;
                    end else if (bus.ready_in) begin
                        valid_out_q <= 1'b0;
                        ready_out_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_out = ready_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.x_o       = x_o_q;
    assign bus.y_o       = y_o_q;
    assign bus.phase_out = ph_o_q;
    assign busy          = busy_q;
endmodule
